// File: rtl/ll2_decimate_2x2_pkg.sv
// ll2_decimate_2x2_pkg
//   Shared definitions for the 2x2 box-average decimator.
//   LL2_DATA_W : default pixel width
//   LL2_PAIR_W : width of a horizontal pair sum (one bit of growth)
//   LL2_SUM_W  : width of a four-pixel sum (two bits of growth)
//   state_t    : handshake FSM encoding
package ll2_decimate_2x2_pkg;

  localparam int LL2_DATA_W = 16;
  localparam int LL2_PAIR_W = LL2_DATA_W + 1;
  localparam int LL2_SUM_W  = LL2_DATA_W + 2;

  typedef enum logic {
    S_TAKE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/ll2_decimate_2x2_linebuf.sv
// ll2_linebuf
//   Simple dual-port RAM holding one even-row line of horizontal pair sums.
//   Synchronous write, registered read, no reset (contents are always
//   rewritten on an even row before the following odd row reads them).
//   Ports:
//     CLK    clock
//     we     write enable
//     waddr  write address
//     wdata  write data (pair sum)
//     raddr  read address, sampled every cycle
//     rdata  registered read data
module ll2_linebuf
  import ll2_decimate_2x2_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = LL2_PAIR_W,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ll2_decimate_2x2.sv
// ll2_decimate_2x2
//   2x2 box-average decimator. Consumes a raster-order pixel stream of an
//   IMG_WIDTH x IMG_HEIGHT frame and emits one rounded average per
//   non-overlapping 2x2 block, (W/2)x(H/2) outputs in raster order.
//   Ports:
//     CLK         clock, rising edge
//     RESET       asynchronous active-high reset
//     In1_DATA    input pixel, valid while In1_SEND=1
//     In1_COUNT   producer token count (unused, always 1)
//     In1_SEND    input token available
//     In1_ACK     input token consumed this cycle (combinational)
//     Out1_DATA   decimated pixel (registered, held until issued)
//     Out1_COUNT  constant 1
//     Out1_SEND   output token issued this cycle
//     Out1_ACK    unused
//     Out1_RDY    downstream can accept a token this cycle
module ll2_decimate_2x2
  import ll2_decimate_2x2_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = LL2_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic [15:0]       In1_COUNT,
  input  logic              In1_SEND,
  output logic              In1_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic [15:0]       Out1_COUNT,
  output logic              Out1_SEND,
  input  logic              Out1_ACK,
  input  logic              Out1_RDY
);

  localparam int PAIR_W = DATA_W + 1;
  localparam int SUM_W  = DATA_W + 2;
  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int ADDR_W = (HALF_W     > 1) ? $clog2(HALF_W)     : 1;

  if ((IMG_WIDTH < 2) || ((IMG_WIDTH % 2) != 0)) begin : g_bad_width
    $error("ll2_decimate_2x2: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT < 2) || ((IMG_HEIGHT % 2) != 0)) begin : g_bad_height
    $error("ll2_decimate_2x2: IMG_HEIGHT must be even and >= 2");
  end

  function automatic logic [PAIR_W-1:0] pair_sum(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return PAIR_W'(a) + PAIR_W'(b);
  endfunction

  // Round-half-up divide by four; the 18-bit sum plus 2 cannot overflow,
  // and the quotient always fits DATA_W.
  function automatic logic [DATA_W-1:0] round_avg(input logic [SUM_W-1:0] total);
    logic [SUM_W-1:0] biased;
    biased = total + SUM_W'(2);
    return biased[SUM_W-1:2];
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [DATA_W-1:0]  pair_p0;
  logic               take;
  logic               col_last;
  logic               row_last;
  logic [COL_W:0]     col_ext;
  logic [ADDR_W-1:0]  lb_addr;
  logic               lb_we;
  logic [PAIR_W-1:0]  lb_wdata;
  logic [PAIR_W-1:0]  lb_rdata;
  logic [SUM_W-1:0]   total;
  logic               unused_inputs;

  assign unused_inputs = ^{In1_COUNT, Out1_ACK};
  assign Out1_COUNT    = 16'h0001;

  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));

  // The read address follows col>>1 continuously, so during input gaps the
  // read is simply re-issued and rdata stays valid for the pending odd pixel.
  assign col_ext = {1'b0, col};
  assign lb_addr = ADDR_W'(col_ext >> 1);

  assign lb_we    = take && !row[0] && col[0];
  assign lb_wdata = pair_sum(pair_p0, In1_DATA);
  assign total    = SUM_W'(pair_p0) + SUM_W'(In1_DATA) + SUM_W'(lb_rdata);

  always_comb begin
    state_nxt = state;
    In1_ACK   = 1'b0;
    Out1_SEND = 1'b0;
    case (state)
      S_TAKE: begin
        In1_ACK = In1_SEND && !RESET;
        if (In1_SEND && !RESET && row[0] && col[0]) begin
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        Out1_SEND = Out1_RDY && !RESET;
        if (Out1_RDY) begin
          state_nxt = S_TAKE;
        end
      end
      default: state_nxt = S_TAKE;
    endcase
  end

  assign take = In1_ACK;

  // Stage p0: pixel accepted; pair latched / pair sum written / block finished
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_TAKE;
      col       <= '0;
      row       <= '0;
      pair_p0   <= '0;
      Out1_DATA <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (!col[0]) begin
          pair_p0 <= In1_DATA;
        end
        if (row[0] && col[0]) begin
          Out1_DATA <= round_avg(total);
        end
      end
    end
  end

  ll2_linebuf #(
    .DEPTH  (HALF_W),
    .WIDTH  (PAIR_W),
    .ADDR_W (ADDR_W)
  ) u_linebuf (
    .CLK   (CLK),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

endmodule

// File: tb/tb_ll2_decimate_2x2.sv
// tb_ll2_decimate_2x2
//   Scoreboard bench for ll2_decimate_2x2 on a 4x4 frame. The driver records
//   every accepted pixel into a frame image and, when a 2x2 block completes,
//   pushes the rounded block mean; a monitor pops on every Out1_SEND.
module tb_ll2_decimate_2x2;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DW-1:0] In1_DATA;
  logic [15:0]   In1_COUNT;
  logic          In1_SEND;
  logic          In1_ACK;
  logic [DW-1:0] Out1_DATA;
  logic [15:0]   Out1_COUNT;
  logic          Out1_SEND;
  logic          Out1_ACK;
  logic          Out1_RDY;

  int total = 0;
  int bad   = 0;

  int unsigned   frame [W*H];
  int            px_idx = 0;
  logic [DW-1:0] exp_q [$];
  logic          prev_send = 1'b0;

  ll2_decimate_2x2 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .In1_DATA   (In1_DATA),
    .In1_COUNT  (In1_COUNT),
    .In1_SEND   (In1_SEND),
    .In1_ACK    (In1_ACK),
    .Out1_DATA  (Out1_DATA),
    .Out1_COUNT (Out1_COUNT),
    .Out1_SEND  (Out1_SEND),
    .Out1_ACK   (Out1_ACK),
    .Out1_RDY   (Out1_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: place pixel in the frame image; a pixel landing on an
  // odd row and odd column closes a 2x2 block whose rounded mean is expected.
  task automatic accept(input logic [DW-1:0] v);
    int r, c;
    int unsigned s;
    r = px_idx / W;
    c = px_idx % W;
    frame[px_idx] = v;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      s = frame[(r-1)*W + c-1] + frame[(r-1)*W + c] + frame[r*W + c-1] + frame[r*W + c];
      exp_q.push_back(DW'((s + 2) / 4));
    end
    px_idx = (px_idx + 1) % (W*H);
  endtask

  task automatic push_px(input logic [DW-1:0] v, input bit gaps);
    int  n;
    bit  done;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        In1_SEND = 1'b0;
        @(posedge CLK); #1;
      end
    end
    In1_DATA = v;
    In1_SEND = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge CLK);
      if (In1_ACK) begin
        accept(v);
        done = 1'b1;
      end else if (n >= 500) begin
        chk("ack_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
      n++;
      @(posedge CLK); #1;
    end
    In1_SEND = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    @(posedge CLK); #1;
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    @(negedge CLK);
    chk("rst_in1_ack",     In1_ACK,    0);
    chk("rst_out1_send",   Out1_SEND,  0);
    chk("rst_out1_data",   Out1_DATA,  0);
    chk("rst_out1_count",  Out1_COUNT, 16'h1);
  endtask

  // Monitor: compare every issued token against the scoreboard.
  always @(negedge CLK) begin
    if (!RESET && Out1_SEND) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_token", Out1_DATA, 32'hDEAD_BEEF);
      end else begin
        chk("token", Out1_DATA, exp_q.pop_front());
      end
      chk("token_count", Out1_COUNT, 16'h1);
      chk("send_pulse", prev_send, 1'b0);
      chk("ack_while_send", In1_ACK, 1'b0);
    end
    prev_send <= Out1_SEND;
  end

  initial begin
    logic [DW-1:0] pix;
    logic [DW-1:0] held;
    logic [DW-1:0] blk [W*H];

    RESET     = 1'b1;
    In1_DATA  = '0;
    In1_COUNT = 16'h1;
    In1_SEND  = 1'b1;
    Out1_ACK  = 1'b0;
    Out1_RDY  = 1'b1;
    repeat (2) @(posedge CLK);
    check_reset_outputs();
    @(posedge CLK); #1;
    In1_SEND = 1'b0;
    RESET    = 1'b0;
    @(posedge CLK); #1;

    // Constant frame
    for (int i = 0; i < W*H; i++) push_px(16'd100, 1'b0);
    drain("const_drain");

    // Ramp 0..15
    for (int i = 0; i < W*H; i++) push_px(DW'(i), 1'b0);
    drain("ramp_drain");

    // Rounding and extremes: {1,2,2,2}, all 0xFFFF, all 0, random block
    blk = '{16'd1, 16'd2, 16'hFFFF, 16'hFFFF,
            16'd2, 16'd2, 16'hFFFF, 16'hFFFF,
            16'd0, 16'd0, 16'd0,    16'd0,
            16'd0, 16'd0, 16'd0,    16'd0};
    for (int i = 0; i < 4; i++) begin
      pix = DW'($urandom);
      blk[(8 + (i/2)*4) + 2 + (i%2)] = pix;
    end
    for (int i = 0; i < W*H; i++) push_px(blk[i], 1'b0);
    drain("extreme_drain");

    // Backpressure on the first result of a ramp frame
    Out1_RDY = 1'b0;
    for (int i = 0; i < 6; i++) push_px(DW'(i), 1'b0);
    held     = exp_q[0];
    In1_DATA = 16'd6;
    In1_SEND = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("stall_send", Out1_SEND, 0);
      chk("stall_ack",  In1_ACK,   0);
      chk("stall_hold", Out1_DATA, held);
    end
    @(posedge CLK); #1;
    Out1_RDY = 1'b1;
    @(negedge CLK);
    chk("release_send", Out1_SEND, 1);
    chk("release_ack",  In1_ACK,   0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("resume_send", Out1_SEND, 0);
    chk("resume_ack",  In1_ACK,   1);
    @(posedge CLK); #1;
    accept(16'd6);
    In1_SEND = 1'b0;
    for (int i = 7; i < W*H; i++) push_px(DW'(i), 1'b0);
    drain("bp_drain");

    // Two back-to-back random frames with random input gaps
    for (int i = 0; i < 2*W*H; i++) begin
      pix = DW'($urandom);
      push_px(pix, 1'b1);
    end
    drain("gap_drain");

    // Reset after six pixels of a frame
    for (int i = 0; i < 6; i++) push_px(DW'(200 + i*7), 1'b0);
    drain("pre_reset_drain");
    RESET    = 1'b1;
    In1_SEND = 1'b1;
    px_idx   = 0;
    exp_q.delete();
    check_reset_outputs();
    @(posedge CLK); #1;
    In1_SEND = 1'b0;
    RESET    = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < W*H; i++) begin
      pix = DW'($urandom);
      push_px(pix, 1'b0);
    end
    drain("post_reset_drain");

    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
